// File: rtl/fft_sequencer_if.sv
// Signal bundle shared by the FFT sequencer, its sample source/sink and the external butterfly unit.
// The slave modport is the sequencer's view; master is the surrounding system.
interface fft_sequencer_if #(
    parameter int Q = 15
);
    logic              valid_in;
    logic              ready_in;
    logic signed [Q:0] data_in_real_0;
    logic signed [Q:0] data_in_imag_0;
    logic signed [Q:0] data_in_real_1;
    logic signed [Q:0] data_in_imag_1;

    logic              bf_valid_out;
    logic signed [Q:0] bf_a_real;
    logic signed [Q:0] bf_a_imag;
    logic signed [Q:0] bf_b_real;
    logic signed [Q:0] bf_b_imag;
    logic [1:0]        bf_tw_idx;

    logic              bf_valid_in;
    logic signed [Q:0] bf_x_real;
    logic signed [Q:0] bf_x_imag;
    logic signed [Q:0] bf_y_real;
    logic signed [Q:0] bf_y_imag;

    logic              valid_out;
    logic signed [Q:0] data_out_real_0;
    logic signed [Q:0] data_out_imag_0;
    logic signed [Q:0] data_out_real_1;
    logic signed [Q:0] data_out_imag_1;
    logic              done;

    modport master (
        output valid_in, data_in_real_0, data_in_imag_0, data_in_real_1, data_in_imag_1,
        output bf_valid_in, bf_x_real, bf_x_imag, bf_y_real, bf_y_imag,
        input  ready_in, bf_valid_out, bf_a_real, bf_a_imag, bf_b_real, bf_b_imag, bf_tw_idx,
        input  valid_out, data_out_real_0, data_out_imag_0, data_out_real_1, data_out_imag_1, done
    );

    modport slave (
        input  valid_in, data_in_real_0, data_in_imag_0, data_in_real_1, data_in_imag_1,
        input  bf_valid_in, bf_x_real, bf_x_imag, bf_y_real, bf_y_imag,
        output ready_in, bf_valid_out, bf_a_real, bf_a_imag, bf_b_real, bf_b_imag, bf_tw_idx,
        output valid_out, data_out_real_0, data_out_imag_0, data_out_real_1, data_out_imag_1, done
    );
endinterface

// File: rtl/fft_sequencer.sv
// In-place radix-2 DIT sequencer for an 8-point FFT: loads samples into bit-reversed slots, issues
// one butterfly at a time to an external unit, then streams the bins out in natural order.
module fft_sequencer #(
    parameter int Q = 15,
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    fft_sequencer_if.slave bus
);
    // state   | meaning
    // IDLE    | counters cleared, lasts one cycle
    // LOAD    | accept four input pairs into bit-reversed slots
    // ISSUE   | present one butterfly for a single cycle
    // WAIT_BF | hold until the butterfly result returns
    // UNLOAD  | four output beats, each followed by one idle cycle
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT_BF, S_UNLOAD} state_t;

    localparam logic [1:0] LAST_S = 2'($clog2(N) - 1);
    localparam logic [1:0] LAST_B = 2'(N / 2 - 1);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_s, r_b, r_m;
    logic              r_gap;
    logic signed [Q:0] r_buf_re [8];
    logic signed [Q:0] r_buf_im [8];
    logic signed [Q:0] r_op_a_re, r_op_a_im, r_op_b_re, r_op_b_im;
    logic [1:0]        r_op_tw;
    logic signed [Q:0] r_out_re0, r_out_im0, r_out_re1, r_out_im1;

    logic              w_load, w_issue, w_bf_wr, w_beat, w_last_bf;
    logic [2:0]        w_top, w_bot, w_span, w_ld0, w_ld1, w_ev, w_od;
    logic [1:0]        w_tw;

    assign w_last_bf = (r_s == LAST_S) && (r_b == LAST_B);
    // 3-bit bit reversal of {m,0} and {m,1}
    assign w_ld0 = {1'b0, r_m[0], r_m[1]};
    assign w_ld1 = {1'b1, r_m[0], r_m[1]};
    assign w_ev  = {r_m, 1'b0};
    assign w_od  = {r_m, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_issue     = 1'b0;
        w_bf_wr     = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            S_IDLE:    w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (bus.valid_in) begin
                    w_load = 1'b1;
                    if (r_m == 2'd3) w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = S_WAIT_BF;
            end
            S_WAIT_BF: begin
                if (bus.bf_valid_in) begin
                    w_bf_wr     = 1'b1;
                    w_state_nxt = w_last_bf ? S_UNLOAD : S_ISSUE;
                end
            end
            S_UNLOAD: begin
                if (!r_gap)            w_beat      = 1'b1;
                else if (r_m == 2'd3) w_state_nxt = S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // top = (b >> s) * 2 * span + (b mod span), bottom = top + span, tw = pos << (2 - s)
    always_comb begin
        w_top = 3'd0;
        w_tw  = 2'd0;
        case (r_s)
            2'd0: begin
                w_top = {r_b, 1'b0};
                w_tw  = 2'd0;
            end
            2'd1: begin
                w_top = {r_b[1], 1'b0, r_b[0]};
                w_tw  = {r_b[0], 1'b0};
            end
            default: begin
                w_top = {1'b0, r_b};
                w_tw  = r_b;
            end
        endcase
        w_span = 3'b001 << r_s;
        w_bot  = w_top | w_span;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_load) begin
                r_buf_re[w_ld0] <= bus.data_in_real_0;
                r_buf_im[w_ld0] <= bus.data_in_imag_0;
                r_buf_re[w_ld1] <= bus.data_in_real_1;
                r_buf_im[w_ld1] <= bus.data_in_imag_1;
            end else if (w_bf_wr) begin
                r_buf_re[w_top] <= bus.bf_x_real;
                r_buf_im[w_top] <= bus.bf_x_imag;
                r_buf_re[w_bot] <= bus.bf_y_real;
                r_buf_im[w_bot] <= bus.bf_y_imag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s       <= 2'd0;
            r_b       <= 2'd0;
            r_m       <= 2'd0;
            r_gap     <= 1'b0;
            r_op_a_re <= '0;
            r_op_a_im <= '0;
            r_op_b_re <= '0;
            r_op_b_im <= '0;
            r_op_tw   <= 2'd0;
            r_out_re0 <= '0;
            r_out_im0 <= '0;
            r_out_re1 <= '0;
            r_out_im1 <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_s   <= 2'd0;
                r_b   <= 2'd0;
                r_m   <= 2'd0;
                r_gap <= 1'b0;
            end
            if (w_load) r_m <= r_m + 2'd1;
            if (w_issue) begin
                r_op_a_re <= r_buf_re[w_top];
                r_op_a_im <= r_buf_im[w_top];
                r_op_b_re <= r_buf_re[w_bot];
                r_op_b_im <= r_buf_im[w_bot];
                r_op_tw   <= w_tw;
            end
            if (w_bf_wr) begin
                if (w_last_bf) begin
                    r_s   <= 2'd0;
                    r_b   <= 2'd0;
                    r_m   <= 2'd0;
                    r_gap <= 1'b0;
                end else if (r_b == LAST_B) begin
                    r_b <= 2'd0;
                    r_s <= r_s + 2'd1;
                end else begin
                    r_b <= r_b + 2'd1;
                end
            end
            if (r_state == S_UNLOAD) begin
                if (!r_gap) begin
                    r_gap     <= 1'b1;
                    r_out_re0 <= r_buf_re[w_ev];
                    r_out_im0 <= r_buf_im[w_ev];
                    r_out_re1 <= r_buf_re[w_od];
                    r_out_im1 <= r_buf_im[w_od];
                end else begin
                    r_gap <= 1'b0;
                    r_m   <= r_m + 2'd1;
                end
            end
        end
    end

    // Live values are shown on the valid cycle; registered copies hold them afterwards.
    assign bus.ready_in        = (r_state == S_LOAD);
    assign bus.bf_valid_out    = w_issue;
    assign bus.bf_a_real       = w_issue ? r_buf_re[w_top] : r_op_a_re;
    assign bus.bf_a_imag       = w_issue ? r_buf_im[w_top] : r_op_a_im;
    assign bus.bf_b_real       = w_issue ? r_buf_re[w_bot] : r_op_b_re;
    assign bus.bf_b_imag       = w_issue ? r_buf_im[w_bot] : r_op_b_im;
    assign bus.bf_tw_idx       = w_issue ? w_tw : r_op_tw;
    assign bus.valid_out       = w_beat;
    assign bus.done            = w_beat && (r_m == 2'd3);
    assign bus.data_out_real_0 = w_beat ? r_buf_re[w_ev] : r_out_re0;
    assign bus.data_out_imag_0 = w_beat ? r_buf_im[w_ev] : r_out_im0;
    assign bus.data_out_real_1 = w_beat ? r_buf_re[w_od] : r_out_re1;
    assign bus.data_out_imag_1 = w_beat ? r_buf_im[w_od] : r_out_im1;
endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: plays the sample source and the external butterfly unit, and checks every
// cycle against an in-bench radix-2 FFT model.
module tb_fft_sequencer;
    localparam int Q = 15;

    logic clk;
    logic reset;

    fft_sequencer_if #(.Q(Q)) bus ();

    fft_sequencer #(.Q(Q), .N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int exp_a_re[12], exp_a_im[12], exp_b_re[12], exp_b_im[12], exp_tw[12];
    int exp_out_re[8], exp_out_im[8];
    int log_a_re[12], log_b_re[12], log_tw[12];
    int got_re[8], got_im[8];

    int iss_idx = 0, out_idx = 0, acc = 0, frames_done = 0;
    int hold_a_re = 0, hold_a_im = 0, hold_b_re = 0, hold_b_im = 0, hold_tw = 0;
    int hold_o_re0 = 0, hold_o_im0 = 0, hold_o_re1 = 0, hold_o_im1 = 0;
    bit prev_vo = 1'b0;

    int cur_mode = 0;
    int cur_lat  = 2;
    bit cur_spur = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic int bitrev3(input int i);
        return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
    endfunction

    // Reference butterfly: mode 0 passes operands through, mode 1 is a Q15 DIT butterfly with 1/2 scaling.
    task automatic bfly(input int mode, input int ar, input int ai, input int br, input int bi,
                        input int k, output int xr, output int xi, output int yr, output int yi);
        longint wr, wi, tr, ti;
        if (mode == 0) begin
            xr = ar; xi = ai; yr = br; yi = bi;
        end else begin
            case (k)
                0:       begin wr = 32767;  wi = 0;      end
                1:       begin wr = 23170;  wi = -23170; end
                2:       begin wr = 0;      wi = -32768; end
                default: begin wr = -23170; wi = -23170; end
            endcase
            tr = (longint'(br) * wr - longint'(bi) * wi) >>> 15;
            ti = (longint'(br) * wi + longint'(bi) * wr) >>> 15;
            xr = int'((longint'(ar) + tr) >>> 1);
            xi = int'((longint'(ai) + ti) >>> 1);
            yr = int'((longint'(ar) - tr) >>> 1);
            yi = int'((longint'(ai) - ti) >>> 1);
        end
    endtask

    task automatic build_model(input int re[8], input int im[8], input int mode);
        int vr[8], vi[8];
        int span, pos, top, bot, xr, xi, yr, yi;
        int k = 0;
        for (int i = 0; i < 8; i++) begin
            vr[bitrev3(i)] = re[i];
            vi[bitrev3(i)] = im[i];
        end
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < 4; b++) begin
                span = 1 << s;
                pos  = b % span;
                top  = (b / span) * 2 * span + pos;
                bot  = top + span;
                exp_a_re[k] = vr[top]; exp_a_im[k] = vi[top];
                exp_b_re[k] = vr[bot]; exp_b_im[k] = vi[bot];
                exp_tw[k]   = pos * (4 / span);
                bfly(mode, vr[top], vi[top], vr[bot], vi[bot], exp_tw[k], xr, xi, yr, yi);
                vr[top] = xr; vi[top] = xi; vr[bot] = yr; vi[bot] = yi;
                k++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            exp_out_re[i] = vr[i];
            exp_out_im[i] = vi[i];
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            iss_idx = 0; out_idx = 0; acc = 0; prev_vo = 1'b0;
            hold_a_re = 0; hold_a_im = 0; hold_b_re = 0; hold_b_im = 0; hold_tw = 0;
            hold_o_re0 = 0; hold_o_im0 = 0; hold_o_re1 = 0; hold_o_im1 = 0;
        end else begin
            if (acc == 4) chk("ready_after_load", int'(bus.ready_in), 0);
            if (bus.valid_in && bus.ready_in) acc++;
            if (bus.bf_valid_out) begin
                if (iss_idx < 12) begin
                    chk("issue_a_re", bus.bf_a_real, exp_a_re[iss_idx]);
                    chk("issue_a_im", bus.bf_a_imag, exp_a_im[iss_idx]);
                    chk("issue_b_re", bus.bf_b_real, exp_b_re[iss_idx]);
                    chk("issue_b_im", bus.bf_b_imag, exp_b_im[iss_idx]);
                    chk("issue_tw", int'(bus.bf_tw_idx), exp_tw[iss_idx]);
                    log_a_re[iss_idx] = bus.bf_a_real;
                    log_b_re[iss_idx] = bus.bf_b_real;
                    log_tw[iss_idx]   = int'(bus.bf_tw_idx);
                    hold_a_re = exp_a_re[iss_idx]; hold_a_im = exp_a_im[iss_idx];
                    hold_b_re = exp_b_re[iss_idx]; hold_b_im = exp_b_im[iss_idx];
                    hold_tw   = exp_tw[iss_idx];
                end else begin
                    chk("issue_count", iss_idx, 11);
                end
                iss_idx++;
            end else begin
                chk("hold_a_re", bus.bf_a_real, hold_a_re);
                chk("hold_a_im", bus.bf_a_imag, hold_a_im);
                chk("hold_b_re", bus.bf_b_real, hold_b_re);
                chk("hold_b_im", bus.bf_b_imag, hold_b_im);
                chk("hold_tw", int'(bus.bf_tw_idx), hold_tw);
            end
            if (bus.valid_out) begin
                chk("beat_gap", int'(prev_vo), 0);
                if (out_idx < 4) begin
                    chk("out_re0", bus.data_out_real_0, exp_out_re[2*out_idx]);
                    chk("out_im0", bus.data_out_imag_0, exp_out_im[2*out_idx]);
                    chk("out_re1", bus.data_out_real_1, exp_out_re[2*out_idx+1]);
                    chk("out_im1", bus.data_out_imag_1, exp_out_im[2*out_idx+1]);
                    chk("done_beat", int'(bus.done), (out_idx == 3) ? 1 : 0);
                    got_re[2*out_idx] = bus.data_out_real_0;   got_im[2*out_idx] = bus.data_out_imag_0;
                    got_re[2*out_idx+1] = bus.data_out_real_1; got_im[2*out_idx+1] = bus.data_out_imag_1;
                    hold_o_re0 = exp_out_re[2*out_idx];   hold_o_im0 = exp_out_im[2*out_idx];
                    hold_o_re1 = exp_out_re[2*out_idx+1]; hold_o_im1 = exp_out_im[2*out_idx+1];
                end else begin
                    chk("beat_count", out_idx, 3);
                end
                if (bus.done) begin
                    chk("issues_per_frame", iss_idx, 12);
                    chk("pairs_per_frame", acc, 4);
                    frames_done++;
                    iss_idx = 0; out_idx = 0; acc = 0;
                end else begin
                    out_idx++;
                end
            end else begin
                chk("done_without_beat", int'(bus.done), 0);
                chk("hold_out_re0", bus.data_out_real_0, hold_o_re0);
                chk("hold_out_im0", bus.data_out_imag_0, hold_o_im0);
                chk("hold_out_re1", bus.data_out_real_1, hold_o_re1);
                chk("hold_out_im1", bus.data_out_imag_1, hold_o_im1);
            end
            prev_vo = bus.valid_out;
        end
    end

    // Butterfly unit emulation with programmable latency and optional spurious pulse during ISSUE.
    initial begin
        int ar, ai, br, bi, k, xr, xi, yr, yi;
        bus.bf_valid_in = 1'b0;
        bus.bf_x_real = '0; bus.bf_x_imag = '0; bus.bf_y_real = '0; bus.bf_y_imag = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.bf_valid_out) begin
                ar = bus.bf_a_real; ai = bus.bf_a_imag;
                br = bus.bf_b_real; bi = bus.bf_b_imag;
                k  = int'(bus.bf_tw_idx);
                bfly(cur_mode, ar, ai, br, bi, k, xr, xi, yr, yi);
                if (cur_spur) begin
                    bus.bf_valid_in = 1'b1;
                    bus.bf_x_real = 16'h5a5a; bus.bf_x_imag = 16'h1234;
                    bus.bf_y_real = 16'h7777; bus.bf_y_imag = 16'h0bad;
                end
                @(posedge clk); #1;
                bus.bf_valid_in = 1'b0;
                if (cur_lat > 1) begin
                    repeat (cur_lat - 1) @(posedge clk);
                    #1;
                end
                bus.bf_x_real = 16'(xr); bus.bf_x_imag = 16'(xi);
                bus.bf_y_real = 16'(yr); bus.bf_y_imag = 16'(yi);
                bus.bf_valid_in = 1'b1;
                @(posedge clk); #1;
                bus.bf_valid_in = 1'b0;
            end
        end
    end

    task automatic load_frame(input int re[8], input int im[8], input bit keep_valid);
        bit acc_now;
        int c;
        for (int m = 0; m < 4; m++) begin
            bus.data_in_real_0 = 16'(re[2*m]);   bus.data_in_imag_0 = 16'(im[2*m]);
            bus.data_in_real_1 = 16'(re[2*m+1]); bus.data_in_imag_1 = 16'(im[2*m+1]);
            bus.valid_in = 1'b1;
            c = 0;
            do begin
                @(negedge clk);
                acc_now = bus.ready_in;
                @(posedge clk); #1;
                c++;
            end while (!acc_now && c < 200);
            if (!acc_now) chk("load_timeout", int'(acc_now), 1);
        end
        if (keep_valid) begin
            bus.data_in_real_0 = 16'(re[0]); bus.data_in_imag_0 = 16'(im[0]);
            bus.data_in_real_1 = 16'(re[1]); bus.data_in_imag_1 = 16'(im[1]);
        end else begin
            bus.valid_in = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int start = frames_done;
        int c = 0;
        while (frames_done == start && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("frame_done_timeout", frames_done, start + 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready_in"}, int'(bus.ready_in), 0);
        chk({tag, "_bf_valid_out"}, int'(bus.bf_valid_out), 0);
        chk({tag, "_valid_out"}, int'(bus.valid_out), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_bf_a_real"}, bus.bf_a_real, 0);
        chk({tag, "_bf_b_imag"}, bus.bf_b_imag, 0);
        chk({tag, "_bf_tw_idx"}, int'(bus.bf_tw_idx), 0);
        chk({tag, "_data_out_real_0"}, bus.data_out_real_0, 0);
        chk({tag, "_data_out_imag_1"}, bus.data_out_imag_1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int re_ramp[8], im_zero[8], re_imp[8], re_q[8], im_q[8], ord[8], lats[3];
        int c;
        re_ramp = '{0, 1, 2, 3, 4, 5, 6, 7};
        im_zero = '{0, 0, 0, 0, 0, 0, 0, 0};
        re_imp  = '{16384, 0, 0, 0, 0, 0, 0, 0};
        re_q    = '{1000, -2000, 3000, 400, -500, 600, 7000, -800};
        im_q    = '{100, 200, -300, 50, 0, -600, 250, 900};
        ord     = '{0, 4, 2, 6, 1, 5, 3, 7};
        lats    = '{1, 5, 20};

        reset = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in_real_0 = '0; bus.data_in_imag_0 = '0;
        bus.data_in_real_1 = '0; bus.data_in_imag_1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_all_zero("reset_state");
        @(posedge clk); #1;

        // ramp with pass-through butterfly: natural-order readout of a bit-reversed buffer
        cur_mode = 0; cur_lat = 2; cur_spur = 1'b0;
        build_model(re_ramp, im_zero, 0);
        load_frame(re_ramp, im_zero, 1'b0);
        wait_done(1000);
        chk("first_issue_a", log_a_re[0], 0);
        chk("first_issue_b", log_b_re[0], 4);
        chk("first_issue_tw", log_tw[0], 0);
        chk("s1b1_a", log_a_re[5], 4);
        chk("s1b1_b", log_b_re[5], 6);
        chk("s1b1_tw", log_tw[5], 2);
        chk("s2b3_a", log_a_re[11], 6);
        chk("s2b3_b", log_b_re[11], 7);
        chk("s2b3_tw", log_tw[11], 3);
        for (int i = 0; i < 8; i++) chk("bitrev_order", got_re[i], ord[i]);
        repeat (3) @(posedge clk); #1;

        // impulse through the Q15 butterfly: flat spectrum of 16384/8
        cur_mode = 1;
        build_model(re_imp, im_zero, 1);
        load_frame(re_imp, im_zero, 1'b0);
        wait_done(1000);
        for (int i = 0; i < 8; i++) begin
            chk("impulse_re", got_re[i], 2048);
            chk("impulse_im", got_im[i], 0);
        end
        repeat (3) @(posedge clk); #1;

        // latency sweep with spurious result pulses while a butterfly is being issued
        cur_spur = 1'b1;
        for (int li = 0; li < 3; li++) begin
            cur_lat = lats[li];
            build_model(re_q, im_q, 1);
            load_frame(re_q, im_q, 1'b0);
            wait_done(2000);
            repeat (3) @(posedge clk); #1;
        end
        cur_spur = 1'b0;

        // reset while waiting on a stage-1 butterfly, then a clean frame
        cur_lat = 4;
        build_model(re_q, im_q, 1);
        load_frame(re_q, im_q, 1'b0);
        c = 0;
        while (iss_idx < 5 && c < 500) begin
            @(posedge clk);
            c++;
        end
        chk("reach_stage1", (iss_idx >= 5) ? 1 : 0, 1);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_all_zero("after_reset");
        repeat (10) @(posedge clk); #1;
        cur_lat = 2;
        build_model(re_q, im_q, 1);
        load_frame(re_q, im_q, 1'b0);
        wait_done(1000);
        repeat (3) @(posedge clk); #1;

        // valid_in held high across two frames
        cur_mode = 0;
        build_model(re_ramp, im_zero, 0);
        load_frame(re_ramp, im_zero, 1'b1);
        wait_done(1000);
        load_frame(re_ramp, im_zero, 1'b0);
        wait_done(1000);
        for (int i = 0; i < 8; i++) chk("continuous_order", got_re[i], ord[i]);
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 Parameter Q, default 15, sample MSB index; every data port is signed [Q:0] (Q1.15).
REQ-002 Parameter N, default 8, FFT points; only N=8 is supported (3 stages, 4 butterflies per stage).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 valid_in  in  1  input pair present.
REQ-007 data_in_real_0/imag_0/real_1/imag_1  in  Q+1 each  sample pair (even index, odd index).
REQ-008 ready_in  out  1  sequencer accepts an input pair this cycle.
REQ-009 bf_valid_out  out  1  butterfly operation issued.
REQ-010 bf_a_real/bf_a_imag/bf_b_real/bf_b_imag  out  Q+1 each  butterfly operands (top, bottom).
REQ-011 bf_tw_idx  out  2  twiddle index k into W8^k, k in 0..3.
REQ-012 bf_valid_in  in  1  butterfly result present.
REQ-013 bf_x_real/bf_x_imag/bf_y_real/bf_y_imag  in  Q+1 each  butterfly results (top, bottom).
REQ-014 valid_out  out  1  output pair present.
REQ-015 data_out_real_0/imag_0/real_1/imag_1  out  Q+1 each  output pair (bins 2m, 2m+1).
REQ-016 done  out  1  one-cycle pulse coincident with the last output pair.

Function
REQ-017 States: IDLE, LOAD, ISSUE, WAIT_BF, UNLOAD; internal 8-entry complex buffer.
REQ-018 IDLE: all counters cleared; next cycle goes to LOAD.
REQ-019 LOAD: ready_in=1; each cycle with valid_in=1 accepts pair m (m=0..3); sample 2m is stored at bitrev3(2m) and sample 2m+1 at bitrev3(2m+1).
REQ-020 After the 4th accepted pair, go to ISSUE with stage s=0 and butterfly b=0; valid_in while ready_in=0 is ignored.
REQ-021 Addressing: span=1<<s, pos=b&(span-1), top=(b>>s)*2*span+pos, bottom=top+span, bf_tw_idx=pos<<(2-s).
REQ-022 ISSUE: bf_valid_out=1 for exactly one cycle with buffer[top] on a, buffer[bottom] on b and bf_tw_idx; then go to WAIT_BF.
REQ-023 Exactly one butterfly is outstanding at a time; bf_a/bf_b/bf_tw_idx hold their value until the next issue.
REQ-024 WAIT_BF: on bf_valid_in=1, write x to buffer[top] and y to buffer[bottom]; b increments, wrapping 3->0 with s incrementing; after s=2,b=3 go to UNLOAD, otherwise go to ISSUE.
REQ-025 bf_valid_in outside WAIT_BF is ignored; WAIT_BF has no timeout.
REQ-026 No arithmetic in the sequencer: buffer widths equal port widths, and results are stored unmodified.
REQ-027 UNLOAD: four output beats m=0..3, each valid_out=1 for one cycle carrying buffer[2m], buffer[2m+1], followed by one cycle of valid_out=0.
REQ-028 There is no output backpressure.
REQ-029 done=1 in the same cycle as the m=3 beat; the cycle after the last gap cycle, go to IDLE.
REQ-030 Data outputs hold their last value whenever valid_out=0.

Reset
REQ-031 When reset=1 at a clock edge: state=IDLE; ready_in, bf_valid_out, valid_out and done are 0; all data, operand and bf_tw_idx outputs are 0; counters s, b and m are 0.
REQ-032 Reset in any state aborts the current frame with no further outputs; buffer contents are don't-care.
REQ-033 Reset has priority over valid_in and bf_valid_in in the same cycle.

Verification
REQ-034 Load pairs real=(0,1),(2,3),(4,5),(6,7), imag=0, with the bench butterfly replying x=a, y=b after 2 cycles -> the first issue shows a=0, b=4, tw=0, and the outputs equal the bit-reversed order 0,4,2,6,1,5,3,7.
REQ-035 Same load; log all 12 issues -> stage 1 butterfly 1 has a=buf[1], b=buf[3], tw=2; stage 2 butterfly 3 has a=buf[3], b=buf[7], tw=3.
REQ-036 Impulse real x[0]=16384 with a Q15 reference butterfly -> all 8 output bins are real 2048 (after 3 x 1/2 stage scaling in the model), imag 0; done=1 with the 4th beat.
REQ-037 Vary bf_valid_in latency over 1, 5 and 20 cycles, with spurious bf_valid_in pulses during ISSUE -> results identical, exactly 12 bf_valid_out pulses.
REQ-038 Assert reset during WAIT_BF of stage 1 -> the next cycle all outputs are 0 and state=IDLE; a following clean frame produces correct results.
REQ-039 Hold valid_in=1 continuously across frames -> only 4 pairs are accepted per frame; ready_in=0 from ISSUE through the end of UNLOAD.
